// File: rtl/rf_mem_pkg.sv
// rtl/rf_mem_pkg.sv - shared types and constants for the register-file/memory sequencer
package rf_mem_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_CAP  = 3'd3,
    ST_WR      = 3'd4,
    ST_FIN     = 3'd5
  } state_t;

  localparam logic [1:0] MEM_READ_CAPTURE = 2'b11;
  localparam logic [1:0] MEM_READ_IDLE    = 2'b00;

  // Register-file roles used by load/store transactions
  localparam int REG_ADDR = 0;
  localparam int REG_DATA = 1;

  localparam int DEFAULT_NUM_REGS = 14;

endpackage

// File: rtl/rf_mem_seq.sv
// rtl/rf_mem_seq.sv - clear sweep, load/store sequencing and C-bus gating for the register file
module rf_mem_seq
  import rf_mem_pkg::*;
#(
  parameter int NUM_REGS    = DEFAULT_NUM_REGS,
  parameter int MEM_LATENCY = 2
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       LOAD_REQ,
  input  logic       STORE_REQ,
  input  logic       CU_C_EN,
  output logic       BUSY,
  output logic       DONE,
  output logic       DM_RE,
  output logic       DM_WE,
  output logic [1:0] MEM_READ,
  output logic       RF_RST,
  output logic [3:0] RF_RST_SEL,
  output logic       C_EN_OUT,
  output logic       C_STALL
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LATENCY - 1);
  localparam logic [CW-1:0] LAT_ONE  = CW'(1);
  localparam logic [CW-1:0] LAT_ZERO = '0;
  localparam logic [3:0]    LAST_IDX = 4'(NUM_REGS - 1);

  state_t        state;
  logic [3:0]    sweep_idx;
  logic [CW-1:0] lat_cnt;

  // Sweep-done is detected from the registered strobe, so the last entry keeps
  // its clear cycle inside INIT and the C-bus stays blocked for all of it.
  // State, counters and every registered output advance together here.
  always_ff @(posedge clk) begin
    if (!RST) begin
      state      <= ST_INIT;
      sweep_idx  <= 4'd0;
      lat_cnt    <= LAT_ZERO;
      BUSY       <= 1'b1;
      DONE       <= 1'b0;
      DM_RE      <= 1'b0;
      DM_WE      <= 1'b0;
      MEM_READ   <= MEM_READ_IDLE;
      RF_RST     <= 1'b0;
      RF_RST_SEL <= 4'd0;
    end else begin
      BUSY     <= 1'b1;
      DONE     <= 1'b0;
      DM_RE    <= 1'b0;
      DM_WE    <= 1'b0;
      MEM_READ <= MEM_READ_IDLE;
      RF_RST   <= 1'b0;
      case (state)
        ST_INIT: begin
          if (RF_RST && (RF_RST_SEL == LAST_IDX)) begin
            state      <= ST_IDLE;
            BUSY       <= 1'b0;
            sweep_idx  <= 4'd0;
            RF_RST_SEL <= 4'd0;
          end else begin
            RF_RST     <= 1'b1;
            RF_RST_SEL <= sweep_idx;
            sweep_idx  <= sweep_idx + 4'd1;
          end
        end
        ST_IDLE: begin
          if (LOAD_REQ) begin
            state   <= ST_RD_WAIT;
            DM_RE   <= 1'b1;
            lat_cnt <= LAT_LOAD;
          end else if (STORE_REQ) begin
            state <= ST_WR;
            DM_WE <= 1'b1;
          end else begin
            BUSY <= 1'b0;
          end
        end
        ST_RD_WAIT: begin
          if (lat_cnt == LAT_ZERO) begin
            state    <= ST_RD_CAP;
            MEM_READ <= MEM_READ_CAPTURE;
          end else begin
            lat_cnt <= lat_cnt - LAT_ONE;
            DM_RE   <= 1'b1;
          end
        end
        ST_RD_CAP: begin
          state <= ST_FIN;
          DONE  <= 1'b1;
        end
        ST_WR: begin
          state <= ST_FIN;
          DONE  <= 1'b1;
        end
        ST_FIN: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  // C-bus writes are held off while entries are being cleared or regs[1] is captured
  always_comb begin
    C_STALL  = CU_C_EN && ((state == ST_INIT) || (state == ST_RD_CAP));
    C_EN_OUT = CU_C_EN && !((state == ST_INIT) || (state == ST_RD_CAP));
  end

endmodule

// File: tb/tb_rf_mem_seq.sv
// tb/tb_rf_mem_seq.sv - directed self-checking bench for rf_mem_seq
module tb_rf_mem_seq;
  import rf_mem_pkg::*;

  localparam int NREGS = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_req = 1'b0;
  logic       store_req = 1'b0;
  logic       cu_c_en = 1'b0;
  logic       busy, done, dm_re, dm_we, rf_rst, c_en_out, c_stall;
  logic [1:0] mem_read;
  logic [3:0] rf_rst_sel;

  logic [7:0]  mem_data = 8'hA5;
  logic        seed = 1'b0;
  logic [18:0] regs [NREGS];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_mem_seq #(.NUM_REGS(NREGS), .MEM_LATENCY(2)) dut (
    .clk(clk), .RST(rst), .LOAD_REQ(load_req), .STORE_REQ(store_req),
    .CU_C_EN(cu_c_en), .BUSY(busy), .DONE(done), .DM_RE(dm_re), .DM_WE(dm_we),
    .MEM_READ(mem_read), .RF_RST(rf_rst), .RF_RST_SEL(rf_rst_sel),
    .C_EN_OUT(c_en_out), .C_STALL(c_stall)
  );

  // Register-file model: seeded with junk, then cleared/captured by the DUT strobes
  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 19'h7FF00 | 19'(i);
    end else begin
      if (rf_rst && (int'(rf_rst_sel) < NREGS)) regs[rf_rst_sel] <= 19'h0;
      if (mem_read == 2'b11) regs[REG_DATA] <= {11'h0, mem_data};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    cu_c_en = 1'b1;
    rst = 1'b0;
    seed = 1'b1;
    step();
    seed = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rf_rst", 32'(rf_rst), 32'd0);
    chk("rst_sel", 32'(rf_rst_sel), 32'd0);
    chk("rst_dm_re", 32'(dm_re), 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_c_stall", 32'(c_stall), 32'd1);
    chk("rst_c_en_out", 32'(c_en_out), 32'd0);
    rst = 1'b1;
    for (int k = 0; k < NREGS; k++) begin
      step();
      chk($sformatf("sweep_rf_rst_%0d", k), 32'(rf_rst), 32'd1);
      chk($sformatf("sweep_sel_%0d", k), 32'(rf_rst_sel), 32'(k));
      chk($sformatf("sweep_c_stall_%0d", k), 32'(c_stall), 32'd1);
      chk($sformatf("sweep_c_en_out_%0d", k), 32'(c_en_out), 32'd0);
      chk($sformatf("sweep_busy_%0d", k), 32'(busy), 32'd1);
    end
    step();
    chk("post_sweep_rf_rst", 32'(rf_rst), 32'd0);
    chk("post_sweep_busy", 32'(busy), 32'd0);
    chk("post_sweep_c_en_out", 32'(c_en_out), 32'd1);
    for (int i = 0; i < NREGS; i++) chk($sformatf("reg_clear_%0d", i), 32'(regs[i]), 32'd0);
    cu_c_en = 1'b0;
  endtask

  task automatic test_load();
    cu_c_en = 1'b1;
    load_req = 1'b1;
    chk("load_idle_c_en_out", 32'(c_en_out), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("load_dm_re_c%0d", c), 32'(dm_re), 32'(c <= 2));
      chk($sformatf("load_mem_read_c%0d", c), 32'(mem_read), (c == 3) ? 32'h3 : 32'h0);
      chk($sformatf("load_done_c%0d", c), 32'(done), 32'(c == 4));
      chk($sformatf("load_c_en_out_c%0d", c), 32'(c_en_out), 32'(c != 3));
      chk($sformatf("load_c_stall_c%0d", c), 32'(c_stall), 32'(c == 3));
      chk($sformatf("load_busy_c%0d", c), 32'(busy), 32'd1);
      if (c == 4) load_req = 1'b0;
    end
    step();
    chk("load_after_done", 32'(done), 32'd0);
    chk("load_after_busy", 32'(busy), 32'd0);
    chk("load_regs1", 32'(regs[REG_DATA]), 32'h000A5);
    cu_c_en = 1'b0;
  endtask

  task automatic test_store();
    store_req = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      step();
      chk($sformatf("store_dm_we_c%0d", c), 32'(dm_we), 32'(c == 1));
      chk($sformatf("store_done_c%0d", c), 32'(done), 32'(c == 2));
      chk($sformatf("store_mem_read_c%0d", c), 32'(mem_read), 32'h0);
      chk($sformatf("store_dm_re_c%0d", c), 32'(dm_re), 32'd0);
      if (c == 2) store_req = 1'b0;
    end
    step();
    chk("store_after_done", 32'(done), 32'd0);
    chk("store_after_dm_we", 32'(dm_we), 32'd0);
    chk("store_after_busy", 32'(busy), 32'd0);
  endtask

  task automatic test_both_requests();
    load_req = 1'b1;
    store_req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      chk($sformatf("both_dm_re_c%0d", c), 32'(dm_re), 32'(c <= 2));
      chk($sformatf("both_mem_read_c%0d", c), 32'(mem_read), (c == 3) ? 32'h3 : 32'h0);
      chk($sformatf("both_dm_we_c%0d", c), 32'(dm_we), 32'(c == 6));
      chk($sformatf("both_done_c%0d", c), 32'(done), 32'((c == 4) || (c == 7)));
      chk($sformatf("both_busy_c%0d", c), 32'(busy), 32'(c != 5));
      if (c == 4) load_req = 1'b0;
      if (c == 7) store_req = 1'b0;
    end
    step();
    chk("both_after_busy", 32'(busy), 32'd0);
  endtask

  task automatic test_reset_mid_load();
    load_req = 1'b1;
    step();
    chk("midrst_dm_re_started", 32'(dm_re), 32'd1);
    rst = 1'b0;
    load_req = 1'b0;
    step();
    chk("midrst_dm_re", 32'(dm_re), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_mem_read", 32'(mem_read), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    step();
    chk("midrst_done2", 32'(done), 32'd0);
    rst = 1'b1;
    for (int k = 0; k < NREGS; k++) begin
      step();
      chk($sformatf("resweep_rf_rst_%0d", k), 32'(rf_rst), 32'd1);
      chk($sformatf("resweep_sel_%0d", k), 32'(rf_rst_sel), 32'(k));
      chk($sformatf("resweep_done_%0d", k), 32'(done), 32'd0);
    end
    step();
    chk("resweep_end_busy", 32'(busy), 32'd0);
    chk("resweep_end_rf_rst", 32'(rf_rst), 32'd0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_both_requests();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_mem_seq.md
Name: rf_mem_seq

Overview:
- Sequencer that sits between the control unit, the register file and the data memory.
- After reset it clears every register-file entry in turn, one per cycle. It then runs load and store transactions using register 0 as the address and register 1 as the data, and it drives the register file's MEM_READ capture.
- It also gates the control unit's C-bus writes so they never collide with a memory capture or with the clear sweep.

Parameters:
NUM_REGS, 14, number of register-file entries cleared by the init sweep
MEM_LATENCY, 2, data-memory read latency in cycles (must be >= 1)

Ports:
clk  in  1  clock
RST  in  1  synchronous, active-low reset
LOAD_REQ  in  1  control unit requests mem[regs[0]] -> regs[1], level, held until DONE
STORE_REQ  in  1  control unit requests regs[1] -> mem[regs[0]], level, held until DONE
CU_C_EN  in  1  control unit C-bus write enable
BUSY  out  1  high in any state except IDLE
DONE  out  1  one-cycle pulse when a transaction completes
DM_RE  out  1  data-memory read enable
DM_WE  out  1  data-memory write enable
MEM_READ  out  2  2'b11 = register file captures mem_data into regs[1]; otherwise 2'b00
RF_RST  out  1  active-high clear strobe to the register file
RF_RST_SEL  out  4  index of the entry being cleared
C_EN_OUT  out  1  gated C-bus enable to the register file
C_STALL  out  1  CU_C_EN was blocked this cycle; control unit must hold its write

Behaviour:
- Registered outputs: BUSY, DONE, DM_RE, DM_WE, MEM_READ, RF_RST, RF_RST_SEL. They are decoded from the next state, so they are glitch-free at the register file.
- While RST = 0:
  - state = INIT, sweep index = 0, latency counter = 0.
  - RF_RST = 0, RF_RST_SEL = 0, DM_RE = DM_WE = DONE = 0, MEM_READ = 2'b00, BUSY = 1.
- States: INIT, IDLE, RD_WAIT, RD_CAP, WR, FIN.
- INIT:
  - Starts on the first edge after RST returns to 1.
  - Each cycle: RF_RST = 1 and RF_RST_SEL = index; index increments.
  - After index NUM_REGS-1 has been driven: RF_RST = 0 and the next state is IDLE.
  - Duration is exactly NUM_REGS cycles. LOAD_REQ and STORE_REQ are ignored during the sweep.
- IDLE:
  - LOAD_REQ -> RD_WAIT; else STORE_REQ -> WR.
  - If both requests are high, LOAD wins; STORE stays pending and is served on the next IDLE cycle.
- RD_WAIT: DM_RE = 1 for exactly MEM_LATENCY cycles (down-counter), then -> RD_CAP.
- RD_CAP: DM_RE = 0, MEM_READ = 2'b11 for one cycle, then -> FIN.
- WR: DM_WE = 1 for one cycle, then -> FIN.
- FIN:
  - DONE = 1 for one cycle, then -> IDLE.
  - A request still high in IDLE starts a new transaction, so the requester must drop its request on the DONE cycle.
- Latency from the request being sampled in IDLE to DONE high:
  - Load: MEM_LATENCY+2 cycles.
  - Store: 2 cycles.
- C-bus gating (combinational on state):
  - C_EN_OUT = CU_C_EN and state not in {INIT, RD_CAP}.
  - C_STALL = CU_C_EN and state in {INIT, RD_CAP}.
  - A C-bus write in any other state, including RD_WAIT and WR, passes through unchanged.
- Reset mid-transaction: the current transaction is abandoned with no DONE, all enables drop during reset, and the INIT sweep restarts from index 0.
- Counter width: clog2(MEM_LATENCY+1). Sweep index width: 4 bits; NUM_REGS <= 16.

Decomposition:
- Shared package (rf_mem_pkg): state encoding enum, MEM_READ_CAPTURE = 2'b11, MEM_READ_IDLE = 2'b00, REG_ADDR = 0, REG_DATA = 1, default NUM_REGS.
- No sub-module; a single FSM plus two counters.

Test Plan:
- Reset release: hold RST=0 for 3 cycles, then release.
  - RF_RST=1 for 14 consecutive cycles with RF_RST_SEL 0..13.
  - Then BUSY=0, and every register-file entry reads 0.
- Load: in IDLE, assert LOAD_REQ with MEM_LATENCY=2.
  - DM_RE high for 2 cycles, then MEM_READ=2'b11 for 1 cycle, then DONE on the 4th cycle.
  - With mem_data=8'hA5, regs[1] = 19'h000A5.
- Store: assert STORE_REQ.
  - DM_WE high for exactly 1 cycle, then DONE the next cycle, with no MEM_READ activity.
- Simultaneous requests: LOAD_REQ=STORE_REQ=1.
  - Load completes first (DONE).
  - Then drop LOAD_REQ: store starts the next cycle and produces a second DONE.
- C-bus conflict: CU_C_EN=1 throughout a load.
  - C_EN_OUT=1 except in the RD_CAP cycle, where C_EN_OUT=0 and C_STALL=1.
  - During INIT: C_EN_OUT=0 and C_STALL=1 on every cycle.
- Reset mid-load: drive RST=0 during RD_WAIT.
  - DM_RE drops, no DONE occurs, and the sweep restarts at RF_RST_SEL=0 after release.
